switch_filter: RTL
==================

Name: switch_filter

Overview:
- Debounces one raw board switch or button and produces the clean level and single-cycle edge strobes.
- Those outputs drive the d_ff capture elements and the CPU single-step clock enable.
- Sits between the board I/O pins and the state elements.
- One instance per physical switch.

Parameters:
- STABLE_COUNT, 500000, number of consecutive synchronized samples that must agree before the filtered level changes (10 ms at 50 MHz); legal range 2 to 2^CNT_W.
- CNT_W, 20, width of the stability counter; must satisfy 2^CNT_W >= STABLE_COUNT.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-low reset; sampled on the rising edge of clk; 0 = reset.
- sw_in, input, 1, raw asynchronous switch or button pin; bouncy.
- sw_level, output, 1, debounced registered level of sw_in.
- sw_rise, output, 1, one-cycle strobe on the cycle sw_level goes 0->1.
- sw_fall, output, 1, one-cycle strobe on the cycle sw_level goes 1->0.

Behaviour:
- Reset: reset is synchronous and active-low; one clock and no other clocks.
  - On any rising clk edge with reset==0, clear sync1, sync2, cnt, state=LOW, sw_level=0, sw_rise=0, sw_fall=0.
  - Reset overrides everything, including mid-count; no strobe is emitted on the reset cycle.
- Synchronizer: two flops, sync1<=sw_in and sync2<=sync1. Only sync2 (called s) is used downstream.
- FSM, four states, all outputs registered:
  - LOW (sw_level=0): if s==1, go to WAIT_HIGH and set cnt=0; else stay.
  - WAIT_HIGH (sw_level=0):
    - if s==0, go to LOW (bounce rejected, no strobe);
    - else if cnt==STABLE_COUNT-1, go to HIGH, set sw_level=1, sw_rise=1;
    - else cnt<=cnt+1.
  - HIGH (sw_level=1): if s==0, go to WAIT_LOW and set cnt=0.
  - WAIT_LOW (sw_level=1):
    - if s==1, go to HIGH (no strobe);
    - else if cnt==STABLE_COUNT-1, go to LOW, set sw_level=0, sw_fall=1;
    - else cnt<=cnt+1.
  - Any unused encoding goes to LOW on the next edge.
- Strobes: sw_rise and sw_fall are 0 on every cycle except the single cycle after the committing edge. They are never both 1.
- Latency: sw_in held at the new value beginning at edge E (sync1 captures it at E). sw_level and the strobe change at edge E+STABLE_COUNT+2.
- Glitch rejection: any opposite sample of s during WAIT_* restarts the process from the stable state. A pulse on s shorter than STABLE_COUNT cycles never changes sw_level.
- Counter: cnt never exceeds STABLE_COUNT-1; no wrap. cnt is a don't-care in LOW/HIGH but held at 0.
- Switch held high through reset: after reset releases, the FSM starts in LOW. It produces sw_rise at E+STABLE_COUNT+2, where E is the first edge with reset==1.
- Reset asserted in WAIT_HIGH/WAIT_LOW: the pending transition is abandoned and sw_level returns to 0.

Test Plan (STABLE_COUNT=4, CNT_W=3):
1. reset=0 for 3 cycles with sw_in=1, then reset=1 -> sw_level=0 during reset; sw_rise=1 for exactly one cycle at edge 6 after release; sw_level=1 thereafter.
2. Clean press: sw_in 0->1 captured at edge E and held -> sw_level=1 and sw_rise=1 at E+6; sw_rise=0 at E+7; sw_fall stays 0.
3. Bounce: sw_in pattern 1,1,0,1,0,1,1,1,1,1... -> no change until four consecutive synchronized 1s; exactly one sw_rise pulse; no sw_fall.
4. Glitch rejection: from HIGH, sw_in=0 for 3 cycles, then 1 -> sw_level stays 1; no strobes.
5. Release: from HIGH, sw_in=0 held from edge E -> sw_level=0 and sw_fall=1 at E+6; one cycle wide.
6. Reset mid-count: sw_in=1, reset=0 asserted while in WAIT_HIGH (cnt=2) -> next edge sw_level=0, no strobe, state LOW. After reset=1 with sw_in still 1, sw_rise fires 6 cycles later.

Source files
------------

// File: rtl/switch_filter.sv
// Debounces one raw switch/button input: two-flop synchronizer followed by a
// stability-count FSM producing a registered level and one-cycle edge strobes.
module switch_filter #(
  parameter int unsigned STABLE_COUNT = 500000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic             sync1;
  logic             sync2;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             level_n;
  logic             rise_n;
  logic             fall_n;

  // Synchronizer and all registered state/outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      state    <= LOW;
      cnt      <= '0;
      sw_level <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      sync1    <= sw_in;
      sync2    <= sync1;
      state    <= state_n;
      cnt      <= cnt_n;
      sw_level <= level_n;
      sw_rise  <= rise_n;
      sw_fall  <= fall_n;
    end
  end

  // Next-state logic; any disagreeing sample in a WAIT state falls back to the stable state.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    level_n = sw_level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      LOW: begin
        level_n = 1'b0;
        if (sync2) state_n = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        level_n = 1'b0;
        if (!sync2) begin
          state_n = LOW;
        end else if (cnt == CNT_LAST) begin
          state_n = HIGH;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        level_n = 1'b1;
        if (!sync2) state_n = WAIT_LOW;
      end
      WAIT_LOW: begin
        level_n = 1'b1;
        if (sync2) begin
          state_n = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_n = LOW;
          level_n = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = LOW;
        level_n = 1'b0;
      end
    endcase
  end

endmodule
